// File: rtl/gpio_uart_pkg.sv
// Shared types and bit positions for the GPIO <-> UART bridge.
//   TX/RX FSM state encodings, GPIO_o field positions, status byte layout.
package gpio_uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // GPIO_o field positions
    localparam int unsigned TX_DATA_LSB = 0;
    localparam int unsigned TX_REQ_BIT  = 8;
    localparam int unsigned RX_ACK_BIT  = 9;
    localparam int unsigned RD_SEL_BIT  = 10;

    // Status byte bit positions
    localparam int unsigned BUSY      = 0;
    localparam int unsigned TX_ACK    = 1;
    localparam int unsigned RX_VALID  = 2;
    localparam int unsigned OVERRUN   = 3;
    localparam int unsigned FRAME_ERR = 4;

    // Status byte as returned on GPIO_i when read select is low
    typedef struct packed {
        logic [2:0] rsvd;
        logic       frame_err;
        logic       overrun;
        logic       rx_valid;
        logic       tx_ack;
        logic       busy;
    } status_t;

endpackage

// File: rtl/uart_rx_deserializer.sv
// UART 8N1 receiver: 2-flop synchroniser, RX FSM and shift register.
// Ports:
//   clk, rst          clock, async active-high reset
//   i_rx              asynchronous serial input (idle high)
//   o_byte            last shifted byte (valid when o_byte_valid pulses)
//   o_byte_valid      1-cycle pulse: frame with good stop bit received
//   o_frame_err       1-cycle pulse: frame with stop bit 0 received
module uart_rx_deserializer
    import gpio_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

    logic            r_sync1, r_sync2;
    rx_state_t       r_state, w_state_n;
    logic [TW-1:0]   r_timer, w_timer_n;
    logic [2:0]      r_idx, w_idx_n;
    logic [7:0]      r_shift, w_shift_n;
    logic            r_valid, w_valid_n;
    logic            r_ferr, w_ferr_n;

    // Next-state logic; all sampling uses the synchronised input
    always_comb begin
        w_state_n = r_state;
        w_timer_n = r_timer + TW'(1);
        w_idx_n   = r_idx;
        w_shift_n = r_shift;
        w_valid_n = 1'b0;
        w_ferr_n  = 1'b0;
        case (r_state)
            RX_IDLE: begin
                w_timer_n = '0;
                w_idx_n   = '0;
                if (!r_sync2) w_state_n = RX_START;
            end
            RX_START: begin
                // Mid-start re-check rejects glitches shorter than half a bit
                if (r_timer == HALF_LAST) begin
                    w_timer_n = '0;
                    w_state_n = r_sync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_timer == BIT_LAST) begin
                    w_timer_n = '0;
                    w_shift_n = {r_sync2, r_shift[7:1]};
                    w_idx_n   = r_idx + 3'd1;
                    if (r_idx == 3'd7) w_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (r_timer == BIT_LAST) begin
                    w_timer_n = '0;
                    w_state_n = RX_IDLE;
                    if (r_sync2) w_valid_n = 1'b1;
                    else         w_ferr_n  = 1'b1;
                end
            end
            default: w_state_n = RX_IDLE;
        endcase
    end

    // State registers; synchroniser resets to idle-high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= RX_IDLE;
            r_timer <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_state <= w_state_n;
            r_timer <= w_timer_n;
            r_idx   <= w_idx_n;
            r_shift <= w_shift_n;
            r_valid <= w_valid_n;
            r_ferr  <= w_ferr_n;
        end
    end

    assign o_byte       = r_shift;
    assign o_byte_valid = r_valid;
    assign o_frame_err  = r_ferr;

endmodule

// File: rtl/gpio_uart_bridge.sv
// GPIO <-> UART bridge: toggle-handshaked TX of bytes from the core's GPIO_o
// word, RX holding register and status read back through GPIO_i.
// Ports:
//   clk, rst   clock, async active-high reset
//   GPIO_o     core word: [7:0] TX byte, [8] TX req toggle, [9] RX ack toggle,
//              [10] read select (0 = status, 1 = rx byte), rest ignored
//   GPIO_i     registered byte back to the core
//   rx_i       UART serial input (async, idle high)
//   tx_o       UART serial output (idle high)
module gpio_uart_bridge
    import gpio_uart_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] GPIO_o,
    output logic [7:0]       GPIO_i,
    input  logic             rx_i,
    output logic             tx_o
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);

    // TX path
    tx_state_t       r_tx_state, w_tx_state_n;
    logic [TW-1:0]   r_tx_timer, w_tx_timer_n;
    logic [2:0]      r_tx_idx, w_tx_idx_n;
    logic [7:0]      r_tx_data, w_tx_data_n;
    logic            r_req_lat, w_req_lat_n;
    logic            r_busy, w_busy_n;
    logic            r_tx_ack, w_tx_ack_n;
    logic            r_tx, w_tx_n;
    logic            w_tx_pending;

    // RX holding / handshake
    logic            r_rx_valid, w_rx_valid_n;
    logic            r_overrun, w_overrun_n;
    logic            r_frame_err, w_frame_err_n;
    logic            r_rx_ack_seen, w_rx_ack_seen_n;
    logic [7:0]      r_rx_byte, w_rx_byte_n;

    logic [7:0]      r_gpio_i, w_gpio_i_n;
    status_t         w_status;

    logic [7:0]      w_des_byte;
    logic            w_des_valid;
    logic            w_des_ferr;
    logic            w_unused;

    assign w_unused = &{1'b0, GPIO_o[WIDTH-1:RD_SEL_BIT+1]};

    uart_rx_deserializer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .i_rx         (rx_i),
        .o_byte       (w_des_byte),
        .o_byte_valid (w_des_valid),
        .o_frame_err  (w_des_ferr)
    );

    assign w_tx_pending = GPIO_o[TX_REQ_BIT] != r_tx_ack;

    // TX FSM: tx_o is registered from the next-state value so it changes on
    // the same edge that enters each bit
    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_timer_n = r_tx_timer + TW'(1);
        w_tx_idx_n   = r_tx_idx;
        w_tx_data_n  = r_tx_data;
        w_req_lat_n  = r_req_lat;
        w_busy_n     = r_busy;
        w_tx_ack_n   = r_tx_ack;
        w_tx_n       = r_tx;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_timer_n = '0;
                w_tx_idx_n   = '0;
                w_tx_n       = 1'b1;
                if (w_tx_pending) begin
                    w_tx_data_n  = GPIO_o[TX_DATA_LSB +: 8];
                    w_req_lat_n  = GPIO_o[TX_REQ_BIT];
                    w_busy_n     = 1'b1;
                    w_tx_state_n = TX_START;
                    w_tx_n       = 1'b0;
                end
            end
            TX_START: begin
                if (r_tx_timer == BIT_LAST) begin
                    w_tx_timer_n = '0;
                    w_tx_state_n = TX_DATA;
                    w_tx_n       = r_tx_data[0];
                end
            end
            TX_DATA: begin
                if (r_tx_timer == BIT_LAST) begin
                    w_tx_timer_n = '0;
                    w_tx_idx_n   = r_tx_idx + 3'd1;
                    if (r_tx_idx == 3'd7) begin
                        w_tx_state_n = TX_STOP;
                        w_tx_n       = 1'b1;
                    end else begin
                        w_tx_n = r_tx_data[w_tx_idx_n];
                    end
                end
            end
            TX_STOP: begin
                if (r_tx_timer == BIT_LAST) begin
                    w_tx_timer_n = '0;
                    w_tx_state_n = TX_IDLE;
                    w_busy_n     = 1'b0;
                    w_tx_ack_n   = r_req_lat;
                    w_tx_n       = 1'b1;
                end
            end
            default: w_tx_state_n = TX_IDLE;
        endcase
    end

    // RX holding register: an ack clears first, then a same-edge byte lands
    always_comb begin
        w_rx_valid_n    = r_rx_valid;
        w_overrun_n     = r_overrun;
        w_frame_err_n   = r_frame_err;
        w_rx_ack_seen_n = r_rx_ack_seen;
        w_rx_byte_n     = r_rx_byte;
        if (GPIO_o[RX_ACK_BIT] != r_rx_ack_seen) begin
            w_rx_valid_n    = 1'b0;
            w_overrun_n     = 1'b0;
            w_frame_err_n   = 1'b0;
            w_rx_ack_seen_n = GPIO_o[RX_ACK_BIT];
        end
        if (w_des_valid) begin
            if (w_rx_valid_n) w_overrun_n = 1'b1;
            w_rx_valid_n = 1'b1;
            w_rx_byte_n  = w_des_byte;
        end
        if (w_des_ferr) w_frame_err_n = 1'b1;
    end

    // GPIO_i read mux
    always_comb begin
        w_status           = '0;
        w_status.busy      = r_busy;
        w_status.tx_ack    = r_tx_ack;
        w_status.rx_valid  = r_rx_valid;
        w_status.overrun   = r_overrun;
        w_status.frame_err = r_frame_err;
        w_gpio_i_n = GPIO_o[RD_SEL_BIT] ? r_rx_byte : w_status;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state    <= TX_IDLE;
            r_tx_timer    <= '0;
            r_tx_idx      <= '0;
            r_tx_data     <= '0;
            r_req_lat     <= 1'b0;
            r_busy        <= 1'b0;
            r_tx_ack      <= 1'b0;
            r_tx          <= 1'b1;
            r_rx_valid    <= 1'b0;
            r_overrun     <= 1'b0;
            r_frame_err   <= 1'b0;
            r_rx_ack_seen <= 1'b0;
            r_rx_byte     <= '0;
            r_gpio_i      <= '0;
        end else begin
            r_tx_state    <= w_tx_state_n;
            r_tx_timer    <= w_tx_timer_n;
            r_tx_idx      <= w_tx_idx_n;
            r_tx_data     <= w_tx_data_n;
            r_req_lat     <= w_req_lat_n;
            r_busy        <= w_busy_n;
            r_tx_ack      <= w_tx_ack_n;
            r_tx          <= w_tx_n;
            r_rx_valid    <= w_rx_valid_n;
            r_overrun     <= w_overrun_n;
            r_frame_err   <= w_frame_err_n;
            r_rx_ack_seen <= w_rx_ack_seen_n;
            r_rx_byte     <= w_rx_byte_n;
            r_gpio_i      <= w_gpio_i_n;
        end
    end

    assign tx_o   = r_tx;
    assign GPIO_i = r_gpio_i;

endmodule
